// File: rtl/fmul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fmul_arbiter: round-robin sharing of one pipelined fmul between two ports  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fmul_arbiter #(
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_s,
   input  logic [31:0] req0_t,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_s,
   input  logic [31:0] req1_t,
   output logic        resp0_valid,
   output logic [31:0] resp0_d,
   output logic        resp1_valid,
   output logic [31:0] resp1_d,
   output logic [1:0]  status0,
   output logic [1:0]  status1,
   input  logic [1:0]  status_clr,
   output logic [31:0] fmul_s,
   output logic [31:0] fmul_t,
   input  logic [31:0] fmul_d,
   input  logic        fmul_overflow,
   input  logic        fmul_underflow,
   output logic        busy
);

   logic             r_ptr;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_hs;
   logic [31:0]      r_fmul_s;
   logic [31:0]      r_fmul_t;
   logic [LATENCY:0] r_tag_v;
   logic [LATENCY:0] r_tag_id;
   logic             w_al_v;
   logic             w_al_id;
   logic             w_cap0;
   logic             w_cap1;
   logic             r_resp0_valid;
   logic             r_resp1_valid;
   logic [31:0]      r_resp0_d;
   logic [31:0]      r_resp1_d;
   logic [1:0]       r_status0;
   logic [1:0]       r_status1;

   // Pointer picks the winner only under contention; grants are masked during reset.
   assign w_gnt0 = ~rst & req0_valid & (~req1_valid | ~r_ptr);
   assign w_gnt1 = ~rst & req1_valid & (~req0_valid |  r_ptr);
   assign w_hs   = w_gnt0 | w_gnt1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr    <= 1'b0;
         r_fmul_s <= 32'h0;
         r_fmul_t <= 32'h0;
      end else if (w_hs) begin
         r_ptr    <= w_gnt0;
         r_fmul_s <= w_gnt1 ? req1_s : req0_s;
         r_fmul_t <= w_gnt1 ? req1_t : req0_t;
      end
   end

   // Stage k holds the tag of the operands presented to the multiplier k cycles ago.
   generate
      if (LATENCY == 0) begin : g_tag_single
         always_ff @(posedge clk) begin
            if (rst) begin
               r_tag_v  <= '0;
               r_tag_id <= '0;
            end else begin
               r_tag_v  <= w_hs;
               r_tag_id <= w_gnt1;
            end
         end
      end else begin : g_tag_shift
         always_ff @(posedge clk) begin
            if (rst) begin
               r_tag_v  <= '0;
               r_tag_id <= '0;
            end else begin
               r_tag_v  <= {r_tag_v[LATENCY-1:0], w_hs};
               r_tag_id <= {r_tag_id[LATENCY-1:0], w_gnt1};
            end
         end
      end
   endgenerate

   assign w_al_v  = r_tag_v[LATENCY];
   assign w_al_id = r_tag_id[LATENCY];
   assign w_cap0  = w_al_v & ~w_al_id;
   assign w_cap1  = w_al_v &  w_al_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp0_valid <= 1'b0;
         r_resp1_valid <= 1'b0;
         r_resp0_d     <= 32'h0;
         r_resp1_d     <= 32'h0;
         r_status0     <= 2'b00;
         r_status1     <= 2'b00;
      end else begin
         r_resp0_valid <= w_cap0;
         r_resp1_valid <= w_cap1;
         if (w_cap0) r_resp0_d <= fmul_d;
         if (w_cap1) r_resp1_d <= fmul_d;
         // Clear has priority over a flag arriving in the same cycle.
         if (status_clr[0])
            r_status0 <= 2'b00;
         else if (w_cap0)
            r_status0 <= r_status0 | {fmul_overflow, fmul_underflow};
         if (status_clr[1])
            r_status1 <= 2'b00;
         else if (w_cap1)
            r_status1 <= r_status1 | {fmul_overflow, fmul_underflow};
      end
   end

   assign req0_ready  = w_gnt0;
   assign req1_ready  = w_gnt1;
   assign fmul_s      = r_fmul_s;
   assign fmul_t      = r_fmul_t;
   assign resp0_valid = r_resp0_valid;
   assign resp1_valid = r_resp1_valid;
   assign resp0_d     = r_resp0_d;
   assign resp1_d     = r_resp1_d;
   assign status0     = r_status0;
   assign status1     = r_status1;
   assign busy        = w_hs | (|r_tag_v) | r_resp0_valid | r_resp1_valid;

endmodule
`default_nettype wire

// File: tb/tb_fmul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fmul_arbiter: directed vector bench, LATENCY 2 plus 0 and 5 sweep       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fmul_arbiter;

   localparam logic [31:0] c_Z    = 32'h00000000;
   localparam logic [31:0] c_A    = 32'h3FC00000;
   localparam logic [31:0] c_TWO  = 32'h40000000;
   localparam logic [31:0] c_ONE  = 32'h3F800000;
   localparam logic [31:0] c_MTWO = 32'hC0000000;
   localparam logic [31:0] c_BIG  = 32'h7F000000;
   localparam logic [31:0] c_MIN  = 32'h00800000;
   localparam logic [31:0] c_3    = 32'h40400000;
   localparam logic [31:0] c_4    = 32'h40800000;
   localparam logic [31:0] c_INF  = 32'h7F800000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_s, req0_t, req1_s, req1_t;
   logic [1:0]  status_clr;

   logic        rdy0 [3];
   logic        rdy1 [3];
   logic        rv0  [3];
   logic        rv1  [3];
   logic [31:0] rd0  [3];
   logic [31:0] rd1  [3];
   logic [1:0]  st0  [3];
   logic [1:0]  st1  [3];
   logic        bsy  [3];
   logic [31:0] fs_a [3];
   logic [31:0] ft_a [3];
   logic [31:0] fd_a [3];
   logic        fo_a [3];
   logic        fu_a [3];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Truncating single-precision multiply for normal operands: {ovf, unf, result}.
   function automatic logic [33:0] f_mul(input logic [31:0] a, input logic [31:0] b);
      logic        sgn;
      int          e;
      logic [47:0] m;
      logic [22:0] frac;
      sgn = a[31] ^ b[31];
      if (a[30:23] == 8'h0 || b[30:23] == 8'h0) return {2'b00, sgn, 31'h0};
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (m[47]) begin
         e    = e + 1;
         frac = m[46:24];
      end else begin
         frac = m[45:23];
      end
      if (e >= 255) return {2'b10, sgn, 8'hFF, 23'h0};
      if (e <= 0)   return {2'b01, sgn, 31'h0};
      return {2'b00, sgn, e[7:0], frac};
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 2 : (gi == 1) ? 0 : 5;
      logic [33:0] w_cur;
      logic [33:0] r_hist [0:7];

      assign w_cur = f_mul(fs_a[gi], ft_a[gi]);
      always @(posedge clk) begin
         r_hist[0] <= w_cur;
         for (int k = 1; k < 8; k++) r_hist[k] <= r_hist[k-1];
      end
      assign {fo_a[gi], fu_a[gi], fd_a[gi]} = (L == 0) ? w_cur : r_hist[(L == 0) ? 0 : L-1];

      fmul_arbiter #(.LATENCY(L)) u_dut (
         .clk           (clk),
         .rst           (rst),
         .req0_valid    (req0_valid),
         .req0_ready    (rdy0[gi]),
         .req0_s        (req0_s),
         .req0_t        (req0_t),
         .req1_valid    (req1_valid),
         .req1_ready    (rdy1[gi]),
         .req1_s        (req1_s),
         .req1_t        (req1_t),
         .resp0_valid   (rv0[gi]),
         .resp0_d       (rd0[gi]),
         .resp1_valid   (rv1[gi]),
         .resp1_d       (rd1[gi]),
         .status0       (st0[gi]),
         .status1       (st1[gi]),
         .status_clr    (status_clr),
         .fmul_s        (fs_a[gi]),
         .fmul_t        (ft_a[gi]),
         .fmul_d        (fd_a[gi]),
         .fmul_overflow (fo_a[gi]),
         .fmul_underflow(fu_a[gi]),
         .busy          (bsy[gi])
      );
   end

   typedef struct {
      logic        rst;
      logic        v0;
      logic [31:0] s0, t0;
      logic        v1;
      logic [31:0] s1, t1;
      logic [1:0]  clr;
      logic [1:0]  er;   // {ready1, ready0}
      logic [1:0]  ev;   // {resp1_valid, resp0_valid}
      logic [31:0] ed0, ed1;
      logic [3:0]  es;   // {status1, status0}
      logic        eb;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
      end
   endtask

   task automatic row(input logic a_rst, input logic a_v0, input logic [31:0] a_s0,
                      input logic [31:0] a_t0, input logic a_v1, input logic [31:0] a_s1,
                      input logic [31:0] a_t1, input logic [1:0] a_clr, input logic [1:0] a_er,
                      input logic [1:0] a_ev, input logic [31:0] a_d0, input logic [31:0] a_d1,
                      input logic [3:0] a_es, input logic a_eb);
      vec_t v;
      v.rst = a_rst; v.v0 = a_v0; v.s0 = a_s0; v.t0 = a_t0;
      v.v1 = a_v1; v.s1 = a_s1; v.t1 = a_t1; v.clr = a_clr;
      v.er = a_er; v.ev = a_ev; v.ed0 = a_d0; v.ed1 = a_d1; v.es = a_es; v.eb = a_eb;
      tbl.push_back(v);
   endtask

   task automatic idle(input logic [1:0] a_ev, input logic [31:0] a_d0, input logic [31:0] a_d1,
                       input logic [3:0] a_es, input logic a_eb);
      row(1'b0, 1'b0, c_Z, c_Z, 1'b0, c_Z, c_Z, 2'b00, 2'b00, a_ev, a_d0, a_d1, a_es, a_eb);
   endtask

   task automatic rst_row(input logic [31:0] a_d0, input logic [31:0] a_d1);
      row(1'b1, 1'b0, c_Z, c_Z, 1'b0, c_Z, c_Z, 2'b00, 2'b00, 2'b00, a_d0, a_d1, 4'h0, 1'b0);
   endtask

   task automatic both(input logic a_rst, input logic [1:0] a_er, input logic a_eb);
      row(a_rst, 1'b1, c_TWO, c_TWO, 1'b1, c_ONE, c_MTWO, 2'b00, a_er, 2'b00, c_Z, c_Z, 4'h0, a_eb);
   endtask

   // Expected response of a sweep instance: a grant j rows back that no reset has discarded.
   function automatic logic sweep_v(input int k, input int lat, input int r);
      int j;
      j = k - 2 - lat;
      if (j < 0) return 1'b0;
      if (!tbl[j].er[r]) return 1'b0;
      for (int m = j; m < k; m++) if (tbl[m].rst) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] sweep_d(input int k, input int lat, input int r);
      logic [33:0] p;
      int j;
      j = k - 2 - lat;
      p = (r == 0) ? f_mul(tbl[j].s0, tbl[j].t0) : f_mul(tbl[j].s1, tbl[j].t1);
      return p[31:0];
   endfunction

   initial begin
      // Single op 1.5 x 2.0
      row(1'b0, 1'b1, c_A, c_TWO, 1'b0, c_Z, c_Z, 2'b00, 2'b01, 2'b00, c_Z, c_Z, 4'h0, 1'b1);
      idle(2'b00, c_Z, c_Z, 4'h0, 1'b1);
      idle(2'b00, c_Z, c_Z, 4'h0, 1'b1);
      idle(2'b00, c_Z, c_Z, 4'h0, 1'b1);
      idle(2'b01, c_3, c_Z, 4'h0, 1'b1);
      repeat (5) idle(2'b00, c_3, c_Z, 4'h0, 1'b0);
      rst_row(c_3, c_Z);
      // Contention: strict alternation
      both(1'b0, 2'b01, 1'b1);
      both(1'b0, 2'b10, 1'b1);
      both(1'b0, 2'b01, 1'b1);
      both(1'b0, 2'b10, 1'b1);
      idle(2'b01, c_4, c_Z, 4'h0, 1'b1);
      idle(2'b10, c_4, c_MTWO, 4'h0, 1'b1);
      idle(2'b01, c_4, c_MTWO, 4'h0, 1'b1);
      idle(2'b10, c_4, c_MTWO, 4'h0, 1'b1);
      repeat (3) idle(2'b00, c_4, c_MTWO, 4'h0, 1'b0);
      rst_row(c_4, c_MTWO);
      // Overflow / underflow, sticky status, clear and clear-wins collision
      row(1'b0, 1'b0, c_Z, c_Z, 1'b1, c_BIG, c_BIG, 2'b00, 2'b10, 2'b00, c_Z, c_Z, 4'h0, 1'b1);
      row(1'b0, 1'b1, c_MIN, c_MIN, 1'b0, c_Z, c_Z, 2'b00, 2'b01, 2'b00, c_Z, c_Z, 4'h0, 1'b1);
      row(1'b0, 1'b0, c_Z, c_Z, 1'b1, c_BIG, c_BIG, 2'b00, 2'b10, 2'b00, c_Z, c_Z, 4'h0, 1'b1);
      idle(2'b00, c_Z, c_Z, 4'h0, 1'b1);
      idle(2'b10, c_Z, c_INF, 4'b1000, 1'b1);
      row(1'b0, 1'b0, c_Z, c_Z, 1'b0, c_Z, c_Z, 2'b10, 2'b00, 2'b01, c_Z, c_INF, 4'b1001, 1'b1);
      idle(2'b10, c_Z, c_INF, 4'b0001, 1'b1);
      row(1'b0, 1'b0, c_Z, c_Z, 1'b0, c_Z, c_Z, 2'b01, 2'b00, 2'b00, c_Z, c_INF, 4'b0001, 1'b0);
      idle(2'b00, c_Z, c_INF, 4'h0, 1'b0);
      idle(2'b00, c_Z, c_INF, 4'h0, 1'b0);
      rst_row(c_Z, c_INF);
      // Back-to-back on requester 0 with a gap
      row(1'b0, 1'b1, c_A, c_TWO, 1'b0, c_Z, c_Z, 2'b00, 2'b01, 2'b00, c_Z, c_Z, 4'h0, 1'b1);
      row(1'b0, 1'b1, c_TWO, c_TWO, 1'b0, c_Z, c_Z, 2'b00, 2'b01, 2'b00, c_Z, c_Z, 4'h0, 1'b1);
      idle(2'b00, c_Z, c_Z, 4'h0, 1'b1);
      idle(2'b00, c_Z, c_Z, 4'h0, 1'b1);
      row(1'b0, 1'b1, c_ONE, c_MTWO, 1'b0, c_Z, c_Z, 2'b00, 2'b01, 2'b01, c_3, c_Z, 4'h0, 1'b1);
      idle(2'b01, c_4, c_Z, 4'h0, 1'b1);
      idle(2'b00, c_4, c_Z, 4'h0, 1'b1);
      idle(2'b00, c_4, c_Z, 4'h0, 1'b1);
      idle(2'b01, c_MTWO, c_Z, 4'h0, 1'b1);
      repeat (3) idle(2'b00, c_MTWO, c_Z, 4'h0, 1'b0);
      rst_row(c_MTWO, c_Z);
      // Reset mid-flight: three ops discarded, pointer back to requester 0
      both(1'b0, 2'b01, 1'b1);
      both(1'b0, 2'b10, 1'b1);
      both(1'b0, 2'b01, 1'b1);
      both(1'b1, 2'b00, 1'b1);
      repeat (4) idle(2'b00, c_Z, c_Z, 4'h0, 1'b0);
      both(1'b0, 2'b01, 1'b1);
      repeat (3) idle(2'b00, c_Z, c_Z, 4'h0, 1'b1);
      idle(2'b01, c_4, c_Z, 4'h0, 1'b1);
      repeat (3) idle(2'b00, c_4, c_Z, 4'h0, 1'b0);

      // Reset state and issue-register behaviour
      rst = 1'b1; req0_valid = 1'b1; req0_s = c_A; req0_t = c_TWO;
      req1_valid = 1'b0; req1_s = c_Z; req1_t = c_Z; status_clr = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("ready0_in_reset", -1, 32'(rdy0[0]), 32'h0);
      check("fmul_s_reset", -1, fs_a[0], c_Z);
      check("fmul_t_reset", -1, ft_a[0], c_Z);
      check("busy_reset", -1, 32'(bsy[0]), 32'h0);
      check("status_reset", -1, 32'({st1[0], st0[0]}), 32'h0);
      check("resp_valid_reset", -1, 32'({rv1[0], rv0[0]}), 32'h0);
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b1; req1_s = c_ONE; req1_t = c_MTWO;
      #1;
      check("ready1_single", -1, 32'({rdy1[0], rdy0[0]}), 32'h2);
      @(posedge clk); @(negedge clk);
      req1_valid = 1'b0;
      #1;
      check("fmul_s_issue", -1, fs_a[0], c_ONE);
      check("fmul_t_issue", -1, ft_a[0], c_MTWO);
      @(posedge clk); @(negedge clk);
      req1_s = c_Z; req1_t = c_Z;
      #1;
      check("fmul_s_hold", -1, fs_a[0], c_ONE);
      check("fmul_t_hold", -1, ft_a[0], c_MTWO);
      repeat (10) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); @(negedge clk); rst = 1'b0;

      for (int k = 0; k < tbl.size(); k++) begin
         rst        = tbl[k].rst;
         req0_valid = tbl[k].v0; req0_s = tbl[k].s0; req0_t = tbl[k].t0;
         req1_valid = tbl[k].v1; req1_s = tbl[k].s1; req1_t = tbl[k].t1;
         status_clr = tbl[k].clr;
         #1;
         check("ready", k, 32'({rdy1[0], rdy0[0]}), 32'(tbl[k].er));
         check("resp_valid", k, 32'({rv1[0], rv0[0]}), 32'(tbl[k].ev));
         check("resp0_d", k, rd0[0], tbl[k].ed0);
         check("resp1_d", k, rd1[0], tbl[k].ed1);
         check("status", k, 32'({st1[0], st0[0]}), 32'(tbl[k].es));
         check("busy", k, 32'(bsy[0]), 32'(tbl[k].eb));
         for (int i = 1; i < 3; i++) begin
            int lat;
            lat = (i == 1) ? 0 : 5;
            check((i == 1) ? "lat0_resp0_valid" : "lat5_resp0_valid", k, 32'(rv0[i]),
                  32'(sweep_v(k, lat, 0)));
            check((i == 1) ? "lat0_resp1_valid" : "lat5_resp1_valid", k, 32'(rv1[i]),
                  32'(sweep_v(k, lat, 1)));
            if (sweep_v(k, lat, 0))
               check((i == 1) ? "lat0_resp0_d" : "lat5_resp0_d", k, rd0[i], sweep_d(k, lat, 0));
            if (sweep_v(k, lat, 1))
               check((i == 1) ? "lat0_resp1_d" : "lat5_resp1_d", k, rd1[i], sweep_d(k, lat, 1));
         end
         @(posedge clk); @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
- Shares one pipelined single-precision fmul datapath between two requesters, e.g. two FPU issue ports.
- Arbitrates with round-robin priority and issues at most one operation per cycle.
- Tags each issued operation in a shift register matched to the multiplier latency, and steers each result plus overflow/underflow flags back to the requester that issued it.
- Keeps sticky per-requester exception status.

Parameters:
- LATENCY, 2, cycles from fmul_s/fmul_t presented to matching fmul_d/flags valid; legal range 0..8.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_s  input  32  requester 0 operand s (IEEE-754 single).
- req0_t  input  32  requester 0 operand t.
- req1_valid / req1_ready / req1_s / req1_t  same as above, for requester 1.
- resp0_valid  output  1  one-cycle pulse: result for requester 0.
- resp0_d  output  32  result for requester 0.
- resp1_valid  output  1  one-cycle pulse: result for requester 1.
- resp1_d  output  32  result for requester 1.
- status0  output  2  sticky {overflow, underflow} for requester 0.
- status1  output  2  sticky {overflow, underflow} for requester 1.
- status_clr  input  2  bit i clears statusi.
- fmul_s  output  32  operand s to the multiplier.
- fmul_t  output  32  operand t to the multiplier.
- fmul_d  input  32  multiplier result.
- fmul_overflow  input  1  multiplier overflow flag.
- fmul_underflow  input  1  multiplier underflow flag.
- busy  output  1  any operation in flight.

Behaviour:
- **Clock and reset:** one clock (clk); reset is synchronous and active-high (rst). On rst high at a clock edge, all of the following clear to 0:
  - every output register, tag pipeline entry, resp*_valid, resp*_d and status*;
  - fmul_s/fmul_t (0x00000000);
  - priority pointer (pointer=0 means requester 0 has priority).
- **Reset mid-operation:** in-flight operations are discarded. No resp is produced for them after reset releases.
- **req*_ready:**
  - Combinational from valids and pointer; never asserted while rst=1.
  - Handshake = valid & ready in the same cycle.
  - Requesters must hold valid and operands stable until ready.
- **Arbitration:**
  - Only one valid: that requester is granted.
  - Both valid: the requester selected by the pointer is granted.
  - After any grant, pointer <= index of the non-granted requester, i.e. strict alternation under continuous contention.
  - No grant: pointer unchanged.
  - At most one ready per cycle. There is no backpressure; an issue is possible every cycle.
- **Issue stage:**
  - On a handshake at cycle N, fmul_s/fmul_t register the granted operands, valid at N+1.
  - Without a handshake, fmul_s/fmul_t hold their previous values; the datapath output is ignored because of the tag.
- **Tag pipeline:**
  - {valid, id} is shifted LATENCY+1 stages.
  - The stage aligned with fmul_d carries the tag of the operands presented LATENCY cycles earlier.
- **Response register:**
  - At cycle N+1+LATENCY, when the aligned tag is valid:
    - resp{id}_d <= fmul_d;
    - resp{id}_valid <= 1 for exactly one cycle, seen at N+2+LATENCY;
    - the other resp*_valid <= 0.
  - Total latency is LATENCY+2 cycles (4 at default).
  - resp*_d holds its last value when not valid.
- **Status:**
  - statusi[1] |= fmul_overflow and statusi[0] |= fmul_underflow on the cycle a result for i is captured.
  - If status_clr[i] coincides with a new flag, clear wins for that cycle only; the new flag is lost.
- **busy:** 1 while any tag stage or response register is valid, or a handshake occurs this cycle. It is combinational.
- **Ordering and counts:** responses return in issue order. Maximum in flight is LATENCY+2, and no counter overflow is possible.

Test Plan:
- **Single op, 1.5 × 2.0:** req0 valid with s=0x3FC00000, t=0x40000000 at cycle 1 -> req0_ready=1 at cycle 1; resp0_valid=1 with resp0_d=0x40400000 at cycle 5 (LATENCY=2); resp1_valid stays 0.
- **Contention after reset:** both valid continuously with req0 0x40000000×0x40000000 and req1 0x3F800000×0xC0000000 -> grants alternate 0,1,0,1; responses 0x40800000 (resp0) and 0xC0000000 (resp1) alternate every cycle starting 4 cycles after the first grant.
- **Overflow:** req1 0x7F000000×0x7F000000 with the model fmul asserting overflow -> resp1_d=0x7F800000; status1=2'b10 persists; status_clr=2'b10 -> status1=0 next cycle.
- **Reset mid-flight:** issue 3 ops, then assert rst for 1 cycle while they are in flight -> no resp*_valid afterward, busy=0, pointer=0, status=0.
- **Back-to-back same requester with gaps:** req0 valid at cycles 1, 2 and 5 -> resp0_valid at 5, 6 and 9, in order, with data matching the operands.
- **Latency sweep:** repeat the first two scenarios with LATENCY=0 and LATENCY=5 -> response latency 2 and 7 cycles respectively.
